// File: rtl/harmon_pkg.sv
// Shared helpers for the clock-enable domain blocks: constant log2 and bus width.
package harmon_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int k = 0; k < 31; k++) begin
      if ((1 << r) < value) r++;
    end
    return r;
  endfunction

  function automatic int data_w(input int nb, input int nch);
    return nb * nch;
  endfunction

endpackage

// File: rtl/ce_rate_adapter_if.sv
// Sample stream and status bundle between a producer and the rate adapter.
interface ce_rate_adapter_if #(
  parameter int NB    = 8,
  parameter int NCH   = 2,
  parameter int LOG2D = 3
);
  localparam int DATA_W = harmon_pkg::data_w(NB, NCH);

  logic [DATA_W-1:0] i;
  logic              iv;
  logic              clear_flags;
  logic [DATA_W-1:0] o;
  logic              ov;
  logic              ce_out;
  logic [LOG2D:0]    level;
  logic              overflow;
  logic              underflow;

  modport master (
    output i, iv, clear_flags,
    input  o, ov, ce_out, level, overflow, underflow
  );

  modport slave (
    input  i, iv, clear_flags,
    output o, ov, ce_out, level, overflow, underflow
  );
endinterface

// File: rtl/ce_frac.sv
// Fractional clock-enable generator: strobes NUM times in every DEN cycles.
module ce_frac
  import harmon_pkg::*;
#(
  parameter int NUM = 4,
  parameter int DEN = 5
) (
  input  logic clock,
  input  logic reset,
  output logic strobe
);
  // acc stays below DEN, so acc+NUM < 2*DEN always fits in AW bits.
  localparam int AW = clog2(DEN) + 1;
  localparam logic [AW-1:0] NUM_W = AW'(NUM);
  localparam logic [AW-1:0] DEN_W = AW'(DEN);

  logic [AW-1:0] acc;
  logic [AW-1:0] sum;
  logic          hit;

  always_comb begin
    sum    = acc + NUM_W;
    hit    = (sum >= DEN_W);
    strobe = hit && !reset;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc <= '0;
    end else if (hit) begin
      acc <= sum - DEN_W;
    end else begin
      acc <= sum;
    end
  end
endmodule

// File: rtl/ce_rate_adapter.sv
// Rational rate adapter: buffers irregular input samples in a small FIFO and
// releases them on a fractional OUT_NUM/OUT_DEN output strobe.
module ce_rate_adapter
  import harmon_pkg::*;
#(
  parameter int NB      = 8,
  parameter int NCH     = 2,
  parameter int LOG2D   = 3,
  parameter int OUT_NUM = 4,
  parameter int OUT_DEN = 5
) (
  input  logic                clock,
  input  logic                reset,
  ce_rate_adapter_if.slave    bus
);
  localparam int DATA_W = data_w(NB, NCH);
  localparam int DEPTH  = 2 ** LOG2D;
  localparam logic [LOG2D:0]   LEVEL_FULL = (LOG2D + 1)'(DEPTH);
  localparam logic [LOG2D:0]   LEVEL_ONE  = (LOG2D + 1)'(1);
  localparam logic [LOG2D-1:0] PTR_ONE    = LOG2D'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [LOG2D-1:0]  wr_ptr;
  logic [LOG2D-1:0]  rd_ptr;
  logic [LOG2D:0]    level_q;
  logic [DATA_W-1:0] o_q;
  logic              ov_q;
  logic              ce_q;
  logic              overflow_q;
  logic              underflow_q;

  logic strobe;
  logic empty;
  logic full;
  logic push;
  logic pop;

  ce_frac #(
    .NUM (OUT_NUM),
    .DEN (OUT_DEN)
  ) u_frac (
    .clock  (clock),
    .reset  (reset),
    .strobe (strobe)
  );

  // A full FIFO still accepts a sample when a pop frees a slot on the same edge.
  // A push into an empty FIFO is not visible to a same-cycle strobe.
  always_comb begin
    empty = (level_q == '0);
    full  = (level_q == LEVEL_FULL);
    pop   = strobe && !empty;
    push  = bus.iv && (!full || pop);
  end

  // Storage has no reset so it can map onto distributed RAM; the head is read
  // combinationally before the edge that may overwrite it.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= bus.i;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_q     <= '0;
      o_q         <= '0;
      ov_q        <= 1'b0;
      ce_q        <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      ce_q <= strobe;
      ov_q <= pop;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        o_q    <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + LEVEL_ONE;
        2'b01:   level_q <= level_q - LEVEL_ONE;
        default: level_q <= level_q;
      endcase
      // A flag event on the same cycle as clear_flags keeps the flag set.
      if (bus.iv && full && !pop) begin
        overflow_q <= 1'b1;
      end else if (bus.clear_flags) begin
        overflow_q <= 1'b0;
      end
      if (strobe && empty) begin
        underflow_q <= 1'b1;
      end else if (bus.clear_flags) begin
        underflow_q <= 1'b0;
      end
    end
  end

  assign bus.o         = o_q;
  assign bus.ov        = ov_q;
  assign bus.ce_out    = ce_q;
  assign bus.level     = level_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_ce_rate_adapter.sv
// Bench for ce_rate_adapter: a 4/5 and a 1/1 instance share one stimulus and are
// compared every cycle against a queue-based model of the adapter's rules.
module tb_ce_rate_adapter;
  localparam int NB    = 8;
  localparam int NCH   = 2;
  localparam int LOG2D = 3;
  localparam int DEPTH = 8;
  localparam int DW    = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] stim_i = '0;
  logic          stim_iv = 1'b0;
  logic          stim_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  ce_rate_adapter_if #(.NB(NB), .NCH(NCH), .LOG2D(LOG2D)) bus0 ();
  ce_rate_adapter_if #(.NB(NB), .NCH(NCH), .LOG2D(LOG2D)) bus1 ();

  assign bus0.i = stim_i;
  assign bus0.iv = stim_iv;
  assign bus0.clear_flags = stim_clr;
  assign bus1.i = stim_i;
  assign bus1.iv = stim_iv;
  assign bus1.clear_flags = stim_clr;

  ce_rate_adapter #(.NB(NB), .NCH(NCH), .LOG2D(LOG2D), .OUT_NUM(4), .OUT_DEN(5)) dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (bus0)
  );

  ce_rate_adapter #(.NB(NB), .NCH(NCH), .LOG2D(LOG2D), .OUT_NUM(1), .OUT_DEN(1)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  // Reference model: strobe k after reset fires when floor((n+1)*NUM/DEN) steps.
  logic [DW-1:0] mq [2][$];
  logic [DW-1:0] m_o [2];
  bit            m_ov [2];
  bit            m_ce [2];
  bit            m_ovf [2];
  bit            m_unf [2];
  longint        m_n [2];
  bit            checking = 1'b0;

  function automatic int num_of(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  function automatic int den_of(input int k);
    return (k == 0) ? 5 : 1;
  endfunction

  function automatic bit frac_strobe(input longint n, input int num, input int den);
    longint a, b;
    a = ((n + 1) * num) / den;
    b = (n * num) / den;
    return a != b;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock) begin
    bit s, pop_ok, push_ok;
    int sz;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        mq[k].delete();
        m_o[k] = '0;
        m_ov[k] = 1'b0;
        m_ce[k] = 1'b0;
        m_ovf[k] = 1'b0;
        m_unf[k] = 1'b0;
        m_n[k] = 0;
      end else begin
        s = frac_strobe(m_n[k], num_of(k), den_of(k));
        m_n[k]++;
        sz = mq[k].size();
        pop_ok = s && (sz > 0);
        push_ok = stim_iv && ((sz < DEPTH) || pop_ok);
        m_ce[k] = s;
        m_ov[k] = pop_ok;
        if (pop_ok) m_o[k] = mq[k].pop_front();
        if (s && sz == 0) m_unf[k] = 1'b1;
        else if (stim_clr) m_unf[k] = 1'b0;
        if (stim_iv && sz == DEPTH && !pop_ok) m_ovf[k] = 1'b1;
        else if (stim_clr) m_ovf[k] = 1'b0;
        if (push_ok) mq[k].push_back(stim_i);
      end
    end
    if (reset) checking = 1'b1;
  end

  task automatic check_dut(input int k, input logic [DW-1:0] o, input logic ov, input logic ce,
                           input logic [LOG2D:0] lvl, input logic ovf, input logic unf);
    check_output($sformatf("d%0d_o", k), 32'(o), 32'(m_o[k]));
    check_output($sformatf("d%0d_ov", k), 32'(ov), 32'(m_ov[k]));
    check_output($sformatf("d%0d_ce_out", k), 32'(ce), 32'(m_ce[k]));
    check_output($sformatf("d%0d_level", k), 32'(lvl), 32'(mq[k].size()));
    check_output($sformatf("d%0d_overflow", k), 32'(ovf), 32'(m_ovf[k]));
    check_output($sformatf("d%0d_underflow", k), 32'(unf), 32'(m_unf[k]));
  endtask

  always @(negedge clock) begin
    if (checking) begin
      check_dut(0, bus0.o, bus0.ov, bus0.ce_out, bus0.level, bus0.overflow, bus0.underflow);
      check_dut(1, bus1.o, bus1.ov, bus1.ce_out, bus1.level, bus1.overflow, bus1.underflow);
    end
  end

  // Presents inputs for the next rising edge and returns just after it.
  task automatic apply_stimulus(input logic iv, input logic [DW-1:0] data, input logic clr);
    stim_iv = iv;
    stim_i = data;
    stim_clr = clr;
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [DW-1:0] got [3];
    logic [DW-1:0] prev;
    int            n_got;
    int            max1;
    logic [LOG2D:0] lvl_before;
    bit            found;
    int            rate;

    apply_stimulus(1'b0, '0, 1'b0);
    apply_stimulus(1'b0, '0, 1'b0);
    reset = 1'b0;

    $display("[TB] idle after reset");
    for (int c = 0; c < 20; c++) begin
      apply_stimulus(1'b0, '0, 1'b0);
      check_output("idle_ce0", 32'(bus0.ce_out), 32'((c % 5) != 0));
      check_output("idle_ce1", 32'(bus1.ce_out), 32'(1));
      check_output("idle_ov0", 32'(bus0.ov), 32'(0));
      check_output("idle_level0", 32'(bus0.level), 32'(0));
    end
    check_output("idle_underflow0", 32'(bus0.underflow), 32'(1));

    $display("[TB] three-sample burst");
    apply_stimulus(1'b0, '0, 1'b1);
    n_got = 0;
    for (int c = 0; c < 20; c++) begin
      apply_stimulus(c < 3, (c < 3) ? DW'(16'h0102 + 16'h0202 * c) : '0, 1'b0);
      if (bus0.ov) begin
        if (n_got < 3) got[n_got] = bus0.o;
        n_got++;
      end
    end
    check_output("burst_count", 32'(n_got), 32'(3));
    check_output("burst_o0", 32'(got[0]), 32'h0102);
    check_output("burst_o1", 32'(got[1]), 32'h0304);
    check_output("burst_o2", 32'(got[2]), 32'h0506);
    check_output("burst_level0", 32'(bus0.level), 32'(0));
    check_output("burst_overflow0", 32'(bus0.overflow), 32'(0));

    $display("[TB] continuous input for 60 cycles");
    prev = 16'h0FFF;
    max1 = 0;
    lvl_before = bus0.level;
    for (int c = 0; c < 60; c++) begin
      apply_stimulus(1'b1, DW'(16'h1000 + c), c < 2);
      if (bus0.ov) begin
        check_output("mono_o0", 32'(bus0.o > prev), 32'(1));
        prev = bus0.o;
      end
      if (c >= 1) check_output("unit_ov1", 32'(bus1.ov), 32'(1));
      if (int'(bus1.level) > max1) max1 = int'(bus1.level);
      if (lvl_before == (LOG2D + 1)'(DEPTH) && bus0.ce_out)
        check_output("full_strobe_level0", 32'(bus0.level), 32'(DEPTH));
      lvl_before = bus0.level;
    end
    check_output("sat_level0", 32'(bus0.level), 32'(8));
    check_output("sat_overflow0", 32'(bus0.overflow), 32'(1));
    check_output("unit_overflow1", 32'(bus1.overflow), 32'(0));
    check_output("unit_underflow1", 32'(bus1.underflow), 32'(0));
    check_output("unit_max_level1", 32'(max1 <= 1), 32'(1));

    $display("[TB] reset while partly full");
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (bus0.level == 5) found = 1'b1;
      else apply_stimulus(1'b0, '0, 1'b0);
    end
    check_output("reach_level5", 32'(found), 32'(1));
    reset = 1'b1;
    apply_stimulus(1'b0, '0, 1'b0);
    reset = 1'b0;
    check_output("rst_level0", 32'(bus0.level), 32'(0));
    check_output("rst_ov0", 32'(bus0.ov), 32'(0));
    check_output("rst_overflow0", 32'(bus0.overflow), 32'(0));
    check_output("rst_underflow0", 32'(bus0.underflow), 32'(0));
    apply_stimulus(1'b1, 16'hAAAA, 1'b0);
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      apply_stimulus(1'b0, '0, 1'b0);
      if (bus0.ov) begin
        found = 1'b1;
        check_output("post_rst_first_o0", 32'(bus0.o), 32'hAAAA);
      end
    end
    check_output("post_rst_ov_seen", 32'(found), 32'(1));

    $display("[TB] randomized traffic");
    for (int seg = 0; seg < 4; seg++) begin
      rate = (seg == 0) ? 30 : (seg == 1) ? 70 : (seg == 2) ? 95 : 100;
      for (int c = 0; c < 100; c++) begin
        reset = ($urandom_range(0, 149) == 0);
        apply_stimulus($urandom_range(0, 99) < rate, DW'($urandom), $urandom_range(0, 19) == 0);
      end
    end
    reset = 1'b0;
    apply_stimulus(1'b0, '0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule

// File: doc/ce_rate_adapter.md
Name: ce_rate_adapter

Overview:
- Single-clock rational rate adapter. It moves NCH-channel samples from an irregular input-valid stream onto a fractional output strobe of OUT_NUM/OUT_DEN of the clock rate, with a small FIFO absorbing jitter.
- It replaces paired-clock synchronous crossings, such as 125 MHz to 100 MHz, with clock-enable domains on one master clock.
- It sits between sample producers (ADC/DSP chains) and consumers that run at a derived enable rate.

Parameters:
- NB, 8: bits per channel.
- NCH, 2: channel count; the data bus is NB*NCH bits, with channel k at bits [NB*k +: NB].
- LOG2D, 3: FIFO depth is 2**LOG2D entries.
- OUT_NUM, 4: output strobe numerator.
- OUT_DEN, 5: output strobe denominator. OUT_NUM <= OUT_DEN and OUT_DEN >= 1.

Ports:
- clock  input  1  sole clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high.
- i  input  NB*NCH  input sample, all channels.
- iv  input  1  input valid; a single-cycle qualifier, any pattern allowed.
- o  output  NB*NCH  output sample, registered.
- ov  output  1  output valid; pulses for one cycle per delivered sample.
- ce_out  output  1  registered output-rate strobe; asserts regardless of data availability.
- level  output  LOG2D+1  current FIFO occupancy.
- overflow  output  1  sticky: iv was dropped because the FIFO was full.
- underflow  output  1  sticky: a strobe arrived with the FIFO empty.
- clear_flags  input  1  clears both sticky flags.

Behaviour:
- Reset (synchronous, active-high), applied the cycle after reset is sampled high:
  - Accumulator acc=0, FIFO pointers=0, level=0.
  - o=0, ov=0, ce_out=0, overflow=0, underflow=0.
- Reset asserted mid-operation discards all FIFO contents. Any strobe or ov that would have been issued that cycle is suppressed.
- Strobe generator:
  - acc has width clog2(OUT_DEN)+1.
  - Each cycle: if acc+OUT_NUM >= OUT_DEN, then acc <= acc+OUT_NUM-OUT_DEN and strobe=1; otherwise acc <= acc+OUT_NUM and strobe=0.
  - ce_out is the strobe registered one cycle.
  - With defaults (4/5), strobe runs 0,1,1,1,1 repeating from reset. With OUT_NUM=OUT_DEN it strobes every cycle. With OUT_NUM=0 it never strobes.
- Push:
  - iv=1 with level<DEPTH writes i to the FIFO.
  - iv=1 with level==DEPTH and a pop in the same cycle is also accepted.
  - iv=1 with level==DEPTH and no pop drops the sample and sets overflow.
- Pop:
  - strobe=1 with level>0 reads the head. Next cycle, o holds the head and ov=1.
  - strobe=1 with level==0 sets underflow; next cycle ov=0 and o holds its previous value.
  - A push into an empty FIFO in the same cycle as a strobe does not bypass. The strobe counts as an underflow, and the sample pops on the next strobe.
- Latency: a sample pushed at cycle t is visible to a strobe at t+1 at the earliest, giving ov at t+2.
- Ordering: FIFO order is strict and channels stay aligned; no per-channel skew.
- level updates on the same edge as the push/pop. Simultaneous push and pop leaves level unchanged.
- Pointers are LOG2D bits and wrap modulo DEPTH. level never exceeds DEPTH.
- clear_flags=1 clears both flags. A flag event in the same cycle as clear_flags wins: the flag is set.
- o changes only on a successful pop.

Decomposition:
- Shared package (harmon_pkg): clog2 function, and a DATA_W=NB*NCH localparam helper.
- Sub-module ce_frac: parameters NUM and DEN; ports clock, reset, and output strobe.
  - Reusable for other enable-domain blocks.
- FIFO storage stays inline as a register array; distributed RAM is acceptable, and no read-first dependence is allowed.

Test Plan:
- Reset, then idle 20 cycles with defaults:
  - ce_out follows 0,1,1,1,1 starting cycle 2 after reset release.
  - ov=0 throughout, underflow=1 after the first strobe, level=0.
- Push 0x0102, 0x0304, 0x0506 on consecutive cycles, then iv=0:
  - ov pulses three times with o=0x0102, 0x0304, 0x0506 in order, each on the cycle after a strobe.
  - level returns to 0, overflow=0.
- Defaults, iv every cycle for 60 cycles with incrementing data:
  - level grows by 1 per 5 cycles and saturates at 8.
  - overflow sets at first drop; output sequence is monotonic with gaps only where drops occurred.
- FIFO full (level=8) with iv=1 coinciding with a strobe: sample accepted, level stays 8, overflow unchanged.
- OUT_NUM=OUT_DEN=1, iv every cycle: ov every cycle after 2-cycle latency, level stays at most 1, no flags.
- Reset pulse while level=5: after reset, level=0 and ov=0; next pushed value 0xAAAA is the first output; flags cleared.
